mux_pipe_reg: RTL and testbench

- Parametrised N:1 word multiplexer with a registered output and a valid/ready handshake. Successor to the combinational 2:1 datapath select.
- Used in the pipelined core for operand, writeback and PC-source selection where the select result must cross a stage boundary.
- Output is buffered by a 2-entry skid (main + skid register), so backpressure never drops or duplicates a word.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/mux_n_comb.sv | 41 ++++
 rtl/mux_pipe_reg.sv | 96 +++++++++
 tb/tb_mux_pipe_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the pipelined core's datapath selects.
//   WIDTH_DEFAULT : default data word width used by the select blocks.
//   SEL_*         : named select indices so call sites do not hard-code
//                   magic numbers for operand / writeback / PC-source muxes.
//   sel_in_range  : helper that says whether a select value addresses a
//                   real input of an N-input mux.
package riscv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam int SEL_ALU = 0;
  localparam int SEL_MEM = 1;
  localparam int SEL_PC4 = 2;
  localparam int SEL_IMM = 3;

  function automatic logic sel_in_range(input int sel_value, input int num_in);
    return (sel_value >= 0) && (sel_value < num_in);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N:1 word select.
//   in_data  : NUM_IN words, flattened; word i sits at [i*WIDTH +: WIDTH].
//   sel      : index of the word to forward.
//   out_data : selected word, or all zeros when sel does not name an input.
//   err      : high when sel does not name an input.
// With NUM_IN=2 this is a drop-in replacement for the old 2:1 select.
module mux_n_comb
  import riscv_pkg::*;
#(
  parameter int  WIDTH  = WIDTH_DEFAULT,
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    err
);

  logic [WIDTH-1:0] words [NUM_IN];

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign words[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Default to "no match"; only an in-range index overrides it. When NUM_IN
  // is not a power of two the upper select codes fall through to zero + err.
  always_comb begin
    out_data = '0;
    err      = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        out_data = words[i];
        err      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_reg.sv
// Registered N:1 word select with a valid/ready handshake.
//   clk, rst_n          : rising-edge clock, synchronous active-low reset.
//   in_data, sel        : flattened candidate words and the select index.
//   in_valid / in_ready : upstream handshake; in_ready depends on state only.
//   flush               : discard every buffered word at this edge.
//   out_data/out_valid  : selected word, registered.
//   out_ready           : downstream handshake.
//   sel_err             : sticky, set when an out-of-range select is accepted.
// Two storage slots (main + skid) let the block take one more word after
// downstream stalls, so in_ready never has to follow out_ready
// combinationally and nothing is lost or duplicated.
module mux_pipe_reg
  import riscv_pkg::*;
#(
  parameter int  WIDTH  = WIDTH_DEFAULT,
  parameter int  NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_bad;

  logic [WIDTH-1:0] main_data_reg;
  logic             main_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_valid_reg;
  logic             sel_err_reg;

  logic             accept;

  mux_n_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out_data (sel_word),
    .err      (sel_bad)
  );

  assign in_ready  = !skid_valid_reg;
  assign accept    = in_valid && in_ready;
  assign out_data  = main_data_reg;
  assign out_valid = main_valid_reg;
  assign sel_err   = sel_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_data_reg  <= '0;
      main_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      sel_err_reg    <= 1'b0;
    end else if (flush) begin
      // Data registers keep their contents; the valids are what matter.
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (accept && sel_bad) begin
        sel_err_reg <= 1'b1;
      end

      if (skid_valid_reg) begin
        // Skid only fills while main holds a stalled word, so main is valid
        // here. in_ready is low, so no new word competes for the slots.
        if (out_ready) begin
          main_data_reg  <= skid_data_reg;
          skid_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid_reg || out_ready) begin
          main_data_reg  <= sel_word;
          main_valid_reg <= 1'b1;
        end else begin
          skid_data_reg  <= sel_word;
          skid_valid_reg <= 1'b1;
        end
      end else if (main_valid_reg && out_ready) begin
        main_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_pipe_reg.sv
module tb_mux_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  // Instance A: WIDTH=32, NUM_IN=4
  logic [127:0] a_in_data;
  logic [1:0]   a_sel;
  logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_sel_err;
  logic [31:0]  a_out_data;

  mux_pipe_reg #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sel_err(a_sel_err)
  );

  // Instance C: WIDTH=32, NUM_IN=3 (select code 3 is out of range)
  logic [95:0]  c_in_data;
  logic [1:0]   c_sel;
  logic         c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready, c_sel_err;
  logic [31:0]  c_out_data;

  mux_pipe_reg #(.WIDTH(32), .NUM_IN(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .sel(c_sel),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .flush(c_flush),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .sel_err(c_sel_err)
  );

  // Instance B: WIDTH=8, NUM_IN=16 (random stress)
  logic [127:0] b_in_data;
  logic [3:0]   b_sel;
  logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_sel_err;
  logic [7:0]   b_out_data;

  mux_pipe_reg #(.WIDTH(8), .NUM_IN(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sel_err(b_sel_err)
  );

  logic [31:0] qa[$];
  logic [7:0]  qb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of instance A: score the handshakes that will happen at the
  // coming edge, advance, then compare outputs against the scoreboard.
  task automatic a_step();
    logic [31:0] exp_word;
    if (rst_n && !a_flush && a_out_valid && a_out_ready) begin
      if (qa.size() != 0) begin
        exp_word = qa.pop_front();
        $display("A out word %h (expected %h)", a_out_data, exp_word);
        chk("a_xfer_word", a_out_data, exp_word);
      end else begin
        chk("a_unexpected_word", 32'(a_out_valid), 32'd0);
      end
    end
    if (rst_n && !a_flush && a_in_valid && a_in_ready) begin
      qa.push_back(a_in_data[a_sel*32 +: 32]);
      $display("A accept sel=%0d word %h", a_sel, a_in_data[a_sel*32 +: 32]);
    end
    if (!rst_n || a_flush) qa.delete();
    @(posedge clk); #1;
    chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
    chk("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 2));
    if (qa.size() != 0) chk("a_out_data", a_out_data, qa[0]);
  endtask

  task automatic c_step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] c_words [3];
    logic [7:0]  prev_b;
    logic        hold_b;
    c_words[0] = 32'hAAAA0000;
    c_words[1] = 32'hBBBB0001;
    c_words[2] = 32'hCCCC0002;

    rst_n = 1'b0;
    a_in_data = '0; a_sel = '0; a_in_valid = 0; a_flush = 0; a_out_ready = 0;
    c_in_data = '0; c_sel = '0; c_in_valid = 0; c_flush = 0; c_out_ready = 0;
    b_in_data = '0; b_sel = '0; b_in_valid = 0; b_flush = 0; b_out_ready = 0;

    // Reset state
    a_step(); a_step();
    chk("rst_a_out_data", a_out_data, 32'd0);
    chk("rst_a_sel_err", 32'(a_sel_err), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("rst_c_out_valid", 32'(c_out_valid), 32'd0);
    rst_n = 1'b1;

    // Basic select
    a_in_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    a_out_ready = 1; a_sel = 2'd2; a_in_valid = 1;
    a_step();
    chk("basic_data", a_out_data, 32'hCCCC0002);
    chk("basic_valid", 32'(a_out_valid), 32'd1);
    chk("basic_sel_err", 32'(a_sel_err), 32'd0);
    a_in_valid = 0;
    a_step();

    // Backpressure / skid
    a_out_ready = 0;
    a_sel = 2'd0; a_in_valid = 1; a_step();
    a_sel = 2'd1; a_step();
    chk("skid_in_ready", 32'(a_in_ready), 32'd0);
    chk("skid_hold_data", a_out_data, 32'hAAAA0000);
    a_in_valid = 0;
    a_step(); a_step();
    chk("skid_still_held", a_out_data, 32'hAAAA0000);
    a_out_ready = 1;
    a_step();
    chk("skid_second_word", a_out_data, 32'hBBBB0001);
    chk("skid_ready_back", 32'(a_in_ready), 32'd1);
    a_step();
    chk("skid_drained", 32'(a_out_valid), 32'd0);

    // Flush with full skid and simultaneous accept
    a_out_ready = 0;
    a_sel = 2'd3; a_in_valid = 1; a_step();
    a_sel = 2'd2; a_step();
    a_sel = 2'd1; a_flush = 1; a_step();
    chk("flush_valid", 32'(a_out_valid), 32'd0);
    chk("flush_ready", 32'(a_in_ready), 32'd1);
    chk("flush_sel_err", 32'(a_sel_err), 32'd0);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    a_step(); a_step();

    // Reset mid-stream, with rst_n dropped between edges first
    a_out_ready = 0;
    a_sel = 2'd0; a_in_valid = 1; a_step();
    a_sel = 2'd3; a_step();
    a_in_valid = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_between_edges_valid", 32'(a_out_valid), 32'd1);
    chk("rst_between_edges_ready", 32'(a_in_ready), 32'd0);
    a_step();
    chk("rst_mid_out_data", a_out_data, 32'd0);
    chk("rst_mid_sel_err", 32'(a_sel_err), 32'd0);
    rst_n = 1'b1;
    a_step();

    // Out-of-range select on NUM_IN=3
    c_in_data = {c_words[2], c_words[1], c_words[0]};
    c_out_ready = 1; c_in_valid = 1; c_sel = 2'd1;
    c_step();
    chk("c_inrange_data", c_out_data, 32'hBBBB0001);
    chk("c_inrange_err", 32'(c_sel_err), 32'd0);
    c_sel = 2'd3;
    c_step();
    chk("c_oor_data", c_out_data, 32'd0);
    chk("c_oor_valid", 32'(c_out_valid), 32'd1);
    chk("c_oor_err", 32'(c_sel_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      c_sel = 2'(i % 3);
      c_step();
      chk("c_sticky_data", c_out_data, c_words[i % 3]);
      chk("c_sticky_err", 32'(c_sel_err), 32'd1);
    end
    c_in_valid = 0; c_flush = 1;
    c_step();
    chk("c_flush_valid", 32'(c_out_valid), 32'd0);
    chk("c_flush_keeps_err", 32'(c_sel_err), 32'd1);
    c_flush = 0; rst_n = 1'b0;
    c_step();
    chk("c_rst_err", 32'(c_sel_err), 32'd0);
    rst_n = 1'b1;
    c_step();

    // Random stress on WIDTH=8, NUM_IN=16
    for (int cyc = 0; cyc < 10000; cyc++) begin
      b_in_data   = {$urandom, $urandom, $urandom, $urandom};
      b_sel       = 4'($urandom);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_flush     = ($urandom_range(0, 199) == 0);
      hold_b      = 1'b0;
      prev_b      = b_out_data;
      if (!b_flush && b_out_valid && !b_out_ready) hold_b = 1'b1;
      if (!b_flush && b_out_valid && b_out_ready) begin
        if (qb.size() != 0) chk("b_xfer_word", 32'(b_out_data), 32'(qb.pop_front()));
        else chk("b_unexpected_word", 32'(b_out_valid), 32'd0);
      end
      if (!b_flush && b_in_valid && b_in_ready) qb.push_back(b_in_data[b_sel*8 +: 8]);
      if (b_flush) qb.delete();
      @(posedge clk); #1;
      chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
      chk("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 2));
      if (hold_b) chk("b_hold_stable", 32'(b_out_data), 32'(prev_b));
    end
    chk("b_sel_err", 32'(b_sel_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
